ymat_row_mapper: RTL and testbench
==================================

# ymat_row_mapper

Parametrised successor to the fixed divide-by-16 Y-matrix row stage. It accepts a stream of Y-matrix element indices over a valid/ready handshake and maps each index to an SRAM row address (offset by a programmable base) and a word offset within that row. It flags out-of-range indices, and flags repeated-row accesses so the downstream SRAM reader can skip redundant reads. Results pass through a 2-entry output buffer. The block sits between the Y-matrix column/element sequencer and the SRAM read port.

## Interface
Parameters:
- IDX_W, 16, element index width
- ROW_W, 11, SRAM row address width
- SHIFT, 4, log2 of words per SRAM row; 1 ≤ SHIFT < IDX_W

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  index valid
- in_ready  out  1  block can accept an index
- in_idx  in  IDX_W  element index
- in_last  in  1  last index of a frame (one matrix row pass)
- cfg_base  in  ROW_W  SRAM row base address
- cfg_rows  in  ROW_W+1  number of legal rows; legal raw rows are 0..cfg_rows-1
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_row  out  ROW_W  mapped SRAM row
- out_word  out  SHIFT  word offset within the row
- out_same_row  out  1  row equals the previous in-range row in the same frame
- out_oob  out  1  index out of range
- out_last  out  1  in_last carried through

## Operation
- Accept: in_valid && in_ready at a rising edge.
- raw_row = in_idx >> SHIFT, an (IDX_W-SHIFT)-bit unsigned value. word = in_idx[SHIFT-1:0].
- oob = (raw_row ≥ cfg_rows), compared unsigned at full width. cfg_rows = 0 makes every index oob.
- If not oob: out_row = (cfg_base + raw_row[ROW_W-1:0]) mod 2^ROW_W. The wrap is silent and is not an error.
- If oob: out_row = 0 and out_same_row = 0. out_word and out_last are still carried.
- Same-row tracker:
  - Holds prev_row (IDX_W-SHIFT bits) and prev_vld.
  - out_same_row = prev_vld && !oob && raw_row == prev_row.
  - On each accepted in-range index: prev_row ← raw_row, prev_vld ← 1.
  - oob indices do not update the tracker.
  - Accepting an index with in_last = 1 clears prev_vld after that index is computed. The first index of the next frame therefore always has out_same_row = 0.
- cfg_base and cfg_rows are sampled at the accept edge. Changing them mid-frame is legal and affects only later indices.
- Output buffer:
  - 2-entry FIFO holding {row, word, same_row, oob, last}. count ∈ {0, 1, 2}.
  - Push on accept. Pop on out_valid && out_ready.
  - in_ready = (count < 2), driven from a register (no combinational path from out_ready).
  - out_valid = (count > 0). Outputs present the head entry and stay stable while out_valid && !out_ready.
  - Simultaneous push and pop: count is unchanged and order is preserved.
  - Push is impossible at count = 2 because in_ready = 0.
- Reset:
  - count = 0, prev_vld = 0, in_ready = 1.
  - out_valid = 0, out_row = 0, out_word = 0, out_same_row = 0, out_oob = 0, out_last = 0.
  - Reset mid-frame discards buffered entries and tracker state. No partial output follows reset.

## Timing
- Latency: an index accepted at edge N appears with out_valid = 1 after edge N (visible in cycle N+1). There is no combinational in→out path.
- Throughput: 1 index per clock while out_ready = 1.
- Backpressure: with out_ready = 0, two indices are absorbed. in_ready falls after the second accept edge.
- After out_ready rises: the first pop frees a slot, and in_ready = 1 in the following cycle.
- Tracker update and comparison occur at the accept edge. Back-to-back indices compare correctly with no bubble.

## Test plan
- Basic map (SHIFT=4, cfg_base=0, cfg_rows=2048): idx 0x0123 → row 0x012, word 0x3; idx 0xFFFF → out_oob=1, row 0.
- Base and wrap (cfg_base=0x7F0, cfg_rows=0x800): idx 0x0200 (raw row 0x20) → row 0x010 (wrapped), oob=0.
- Same-row stream: idx 0x10, 0x15, 0x9999 (oob), 0x1F, 0x20 → same_row 0, 1, 0, 1, 0. The oob index does not break the run.
- Frame boundary: idx 0x30 with in_last=1, then 0x31 → second result has same_row=0 and the first has out_last=1.
- Backpressure: hold out_ready=0 and drive 4 indices → only 2 accepted, in_ready=0 from the cycle after the second accept. Release out_ready → all 4 emerge in order, none lost or duplicated.
- Reset mid-operation: with count=2 and prev_vld=1, assert reset for 1 cycle → out_valid=0 and in_ready=1 next cycle; the next index gets same_row=0.

Source files
------------

// File: rtl/ymat_row_mapper.sv
// Maps Y-matrix element indices to SRAM row/word addresses. It flags out-of-range indices
// and repeated rows, and feeds the results through a 2-entry output FIFO.
module ymat_row_mapper #(
   parameter int IDX_W = 16,
   parameter int ROW_W = 11,
   parameter int SHIFT = 4
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [IDX_W-1:0]   in_idx,
   input  logic               in_last,
   input  logic [ROW_W-1:0]   cfg_base,
   input  logic [ROW_W:0]     cfg_rows,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [ROW_W-1:0]   out_row,
   output logic [SHIFT-1:0]   out_word,
   output logic               out_same_row,
   output logic               out_oob,
   output logic               out_last
);
   localparam int RAW_W = IDX_W - SHIFT;
   localparam int CMP_W = (RAW_W > ROW_W + 1) ? RAW_W : ROW_W + 1;
   localparam int ENT_W = ROW_W + SHIFT + 3;

   logic [RAW_W-1:0] raw_row;
   logic [CMP_W-1:0] raw_ext, rows_ext;
   logic [ROW_W-1:0] mapped_row;
   logic             oob, same_row, push, pop;
   logic [ENT_W-1:0] entry_in;

   logic [ENT_W-1:0] mem_q [2];
   logic             rd_ptr_q, wr_ptr_q, in_ready_q;
   logic [1:0]       count_q, count_d;
   logic [RAW_W-1:0] prev_row_q, prev_row_d;
   logic             prev_vld_q, prev_vld_d;

   assign raw_row    = in_idx[IDX_W-1:SHIFT];
   assign raw_ext    = CMP_W'(raw_row);
   assign rows_ext   = CMP_W'(cfg_rows);
   assign oob        = (raw_ext >= rows_ext);
   assign mapped_row = cfg_base + raw_ext[ROW_W-1:0];
   assign same_row   = prev_vld_q && !oob && (raw_row == prev_row_q);
   assign entry_in   = oob ? {{ROW_W{1'b0}}, in_idx[SHIFT-1:0], 1'b0, 1'b1, in_last}
                           : {mapped_row, in_idx[SHIFT-1:0], same_row, 1'b0, in_last};

   assign push      = in_valid && in_ready_q;
   assign pop       = out_valid && out_ready;
   assign in_ready  = in_ready_q;
   assign out_valid = (count_q != 2'd0);
   assign {out_row, out_word, out_same_row, out_oob, out_last} = mem_q[rd_ptr_q];

   always_comb begin
      count_d    = count_q + {1'b0, push} - {1'b0, pop};
      prev_row_d = prev_row_q;
      prev_vld_d = prev_vld_q;
      if (push) begin
         if (!oob) begin
            prev_row_d = raw_row;
            prev_vld_d = 1'b1;
         end
         // Frame end wins: the next frame never starts with a same-row hit.
         if (in_last) prev_vld_d = 1'b0;
      end
   end

   for (genvar gi = 0; gi < 2; gi++) begin : g_ent
      always_ff @(posedge clock) begin
         if (reset)
            mem_q[gi] <= '0;
         else if (push && (wr_ptr_q == 1'(gi)))
            mem_q[gi] <= entry_in;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rd_ptr_q   <= 1'b0;
         wr_ptr_q   <= 1'b0;
         count_q    <= 2'd0;
         in_ready_q <= 1'b1;
         prev_row_q <= '0;
         prev_vld_q <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= ~wr_ptr_q;
         if (pop)  rd_ptr_q <= ~rd_ptr_q;
         count_q    <= count_d;
         in_ready_q <= (count_d < 2'd2);
         prev_row_q <= prev_row_d;
         prev_vld_q <= prev_vld_d;
      end
   end
endmodule

// File: tb/tb_ymat_row_mapper.sv
// Randomized and directed checking of ymat_row_mapper against a queue-based reference model.
module tb_ymat_row_mapper;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_idx = '0;
   logic        in_last = 1'b0;
   logic [10:0] cfg_base = '0;
   logic [11:0] cfg_rows = 12'd2048;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [10:0] out_row;
   logic [3:0]  out_word;
   logic        out_same_row, out_oob, out_last;

   always #5 clock = ~clock;

   ymat_row_mapper #(.IDX_W(16), .ROW_W(11), .SHIFT(4)) dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_idx(in_idx), .in_last(in_last),
      .cfg_base(cfg_base), .cfg_rows(cfg_rows),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_row(out_row), .out_word(out_word), .out_same_row(out_same_row),
      .out_oob(out_oob), .out_last(out_last)
   );

   typedef struct {
      int row;
      int word;
      bit same;
      bit oob;
      bit last;
   } exp_t;

   exp_t q[$];
   int   prev_row = 0;
   bit   prev_vld = 0;
   bit   rst_seen = 1;
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Check the state left by the previous edge, apply new inputs, then advance the model.
   task automatic step(input bit v, input int idx, input bit last, input int base,
                       input int rows, input bit ordy, input bit rst);
      exp_t e;
      bit acc, pp;
      int raw;
      @(negedge clock);
      chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
      chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
      if (rst_seen) begin
         chk("rst_row", 32'(out_row), 0);
         chk("rst_word", 32'(out_word), 0);
         chk("rst_same", 32'(out_same_row), 0);
         chk("rst_oob", 32'(out_oob), 0);
         chk("rst_last", 32'(out_last), 0);
         rst_seen = 0;
      end
      if (q.size() > 0) begin
         chk("row", 32'(out_row), q[0].row);
         chk("word", 32'(out_word), q[0].word);
         chk("same_row", 32'(out_same_row), 32'(q[0].same));
         chk("oob", 32'(out_oob), 32'(q[0].oob));
         chk("last", 32'(out_last), 32'(q[0].last));
      end
      reset     = rst;
      in_valid  = v;
      in_idx    = 16'(idx);
      in_last   = last;
      cfg_base  = 11'(base);
      cfg_rows  = 12'(rows);
      out_ready = ordy;
      if (rst) begin
         q.delete();
         prev_vld = 0;
         rst_seen = 1;
      end else begin
         acc = v && (q.size() < 2);
         pp  = (q.size() > 0) && ordy;
         if (pp) begin
            $display("pop  row=%03h word=%0h same=%0d oob=%0d last=%0d",
                     q[0].row, q[0].word, q[0].same, q[0].oob, q[0].last);
            void'(q.pop_front());
         end
         if (acc) begin
            raw    = idx / 16;
            e.word = idx % 16;
            e.last = last;
            e.oob  = (raw >= rows);
            e.row  = e.oob ? 0 : (base + raw) % 2048;
            e.same = !e.oob && prev_vld && (raw == prev_row);
            q.push_back(e);
            if (!e.oob) begin
               prev_row = raw;
               prev_vld = 1;
            end
            if (last) prev_vld = 0;
         end
      end
   endtask

   initial begin
      step(0, 0, 0, 0, 2048, 1, 1);
      // Basic map and oob
      step(1, 'h0123, 0, 0, 2048, 1, 0);
      step(1, 'hFFFF, 0, 0, 2048, 1, 0);
      // Base with silent wrap
      step(1, 'h0200, 0, 'h7F0, 'h800, 1, 0);
      // Same-row stream with an oob index in the middle, then a frame boundary
      step(1, 'h10, 0, 0, 2048, 1, 0);
      step(1, 'h15, 0, 0, 2048, 1, 0);
      step(1, 'h9999, 0, 0, 2048, 1, 0);
      step(1, 'h1F, 0, 0, 2048, 1, 0);
      step(1, 'h20, 0, 0, 2048, 1, 0);
      step(1, 'h30, 1, 0, 2048, 1, 0);
      step(1, 'h31, 0, 0, 2048, 1, 0);
      step(0, 0, 0, 0, 2048, 1, 0);
      step(0, 0, 0, 0, 2048, 1, 0);
      // cfg_rows = 0 forces oob
      step(1, 'h0005, 0, 'h100, 0, 1, 0);
      // Backpressure: two absorbed, the third held off until release
      step(1, 'h40, 0, 0, 2048, 0, 0);
      step(1, 'h41, 0, 0, 2048, 0, 0);
      step(1, 'h52, 0, 0, 2048, 0, 0);
      step(1, 'h52, 0, 0, 2048, 0, 0);
      step(1, 'h52, 0, 0, 2048, 1, 0);
      step(1, 'h52, 0, 0, 2048, 1, 0);
      step(1, 'h63, 0, 0, 2048, 1, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 2048, 1, 0);
      // Reset with a full buffer and a live tracker
      step(1, 'h70, 0, 0, 2048, 0, 0);
      step(1, 'h71, 0, 0, 2048, 0, 0);
      step(0, 0, 0, 0, 2048, 0, 1);
      step(1, 'h72, 0, 0, 2048, 1, 0);
      step(0, 0, 0, 0, 2048, 1, 0);
      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         int idx, rows;
         idx  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 65535))
                                            : int'($urandom_range(0, 'h1FF));
         rows = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(0, 4095));
         if ($urandom_range(0, 3) == 0) rows = 2048;
         step($urandom_range(0, 3) != 0, idx, $urandom_range(0, 7) == 0,
              int'($urandom_range(0, 2047)), rows, $urandom_range(0, 9) < 7,
              $urandom_range(0, 99) == 0);
      end
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 2048, 1, 0);
      step(0, 0, 0, 0, 2048, 1, 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
